// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: settles the ADC after enable, captures a burst (or a
// continuous run) into a first-word-fall-through FIFO and streams it out.
module adc_capture_ctrl #(
    parameter int ADC_BITLEN     = 16,
    parameter int SETTLE_SAMPLES = 8,
    parameter int BURST_LEN      = 64,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [ADC_BITLEN-1:0] adc_output,
    input  logic                  adc_valid,
    output logic                  adc_rst,
    output logic [ADC_BITLEN-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    input  logic                  clear_ovf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [7:0]    SETTLE_N = 8'(SETTLE_SAMPLES);
    localparam logic [BW-1:0] BURST_N  = BW'(BURST_LEN);
    localparam logic [CW-1:0] DEPTH_N  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [7:0]            settle_cnt_q, settle_cnt_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                  cont_q, cont_d;
    logic                  ovf_q, ovf_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADC_BITLEN-1:0] mem_q [FIFO_DEPTH];
    logic                  fifo_full, fifo_empty;
    logic                  wr_en, rd_en, drop;

    assign fifo_full  = (count_q == DEPTH_N);
    assign fifo_empty = (count_q == '0);
    assign rd_en      = !fifo_empty && m_ready;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        cont_d       = cont_q;
        wr_en        = 1'b0;
        drop         = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cont_d       = continuous;
                    settle_cnt_d = '0;
                    burst_cnt_d  = '0;
                    state_d      = (SETTLE_N == 8'd0) ? CAPTURE : SETTLE;
                end
            end
            SETTLE: begin
                if (adc_valid) begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                    if (settle_cnt_d == SETTLE_N) state_d = CAPTURE;
                end
                if (stop) state_d = DRAIN;
            end
            CAPTURE: begin
                // Full is judged before this cycle's read, so a full FIFO drops even while draining.
                if (adc_valid) begin
                    if (fifo_full) drop  = 1'b1;
                    else           wr_en = 1'b1;
                    if (!cont_q) begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                        if (burst_cnt_d == BURST_N) state_d = DRAIN;
                    end
                end
                if (stop) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !rd_en)      count_d = count_q + CW'(1);
        else if (!wr_en && rd_en) count_d = count_q - CW'(1);
        // A dropped sample wins over a same-cycle clear.
        ovf_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            burst_cnt_q  <= '0;
            cont_q       <= 1'b0;
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            cont_q       <= cont_d;
            ovf_q        <= ovf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage carries no reset; m_data is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= adc_output;
    end

    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign busy     = (state_q != IDLE);
    assign adc_rst  = (state_q == IDLE) || (state_q == DRAIN);
    assign overflow = ovf_q;

endmodule
